// File: rtl/ospi_flash_pkg.sv
// Shared opcodes, state encoding and helpers for the OSPI flash storage core.
package ospi_flash_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WREN   = 3'd1;
    localparam logic [2:0] OP_WRDI   = 3'd2;
    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_PROG   = 3'd4;
    localparam logic [2:0] OP_SERASE = 3'd5;
    localparam logic [2:0] OP_CERASE = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROG,
        ST_ERASE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ospi_flash_array.sv
// Non-volatile word array: synchronous write (program-AND or erase), registered read.
module ospi_flash_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  erase,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Stored inverted so the all-zero power-up content of the RAM reads as erased.
    logic [DATA_WIDTH-1:0] mem_n [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_n[addr] <= erase ? '0 : (mem_n[addr] | ~wdata);
        end
        if (re) begin
            rdata <= ~mem_n[addr];
        end
    end

endmodule

// File: rtl/ospi_flash_core.sv
// Flash storage core: command FSM, write-enable latch, timed program and
// sector/chip erase walks in front of the word array.
module ospi_flash_core
    import ospi_flash_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int SECTOR_WORDS = 16,
    parameter int PROG_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  wel,
    output logic                  err
);

    localparam int ERASE_MAX = 1 << ADDR_WIDTH;
    localparam int CNT_MAX   = (PROG_CYCLES > ERASE_MAX) ? PROG_CYCLES : ERASE_MAX;
    localparam int CW        = clog2(CNT_MAX + 1);

    localparam logic [ADDR_WIDTH-1:0] SECT_MASK = ADDR_WIDTH'(SECTOR_WORDS - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rd_pend;

    logic                  accept;
    logic                  last;
    logic                  arr_we;
    logic                  arr_re;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign last      = (cnt == CW'(1));

    assign arr_we   = (state == ST_ERASE) || ((state == ST_PROG) && last);
    assign arr_re   = accept && (cmd_op == OP_READ);
    assign arr_addr = busy ? addr_q : cmd_addr;

    ospi_flash_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .erase(state == ST_ERASE),
        .addr (arr_addr),
        .wdata(data_q),
        .re   (arr_re),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wel      <= 1'b0;
            err      <= 1'b0;
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            err      <= 1'b0;
            rd_pend  <= 1'b0;
            rd_valid <= rd_pend;
            if (rd_pend) rd_data <= arr_rdata;

            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            cmd_op == OP_WREN: wel <= 1'b1;
                            cmd_op == OP_WRDI: wel <= 1'b0;
                            cmd_op == OP_READ: rd_pend <= 1'b1;
                            cmd_op == OP_PROG: begin
                                if (wel) begin
                                    state  <= ST_PROG;
                                    cnt    <= CW'(PROG_CYCLES);
                                    addr_q <= cmd_addr;
                                    data_q <= cmd_data;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            cmd_op == OP_SERASE: begin
                                if (wel) begin
                                    state  <= ST_ERASE;
                                    cnt    <= CW'(SECTOR_WORDS);
                                    addr_q <= cmd_addr & ~SECT_MASK;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            cmd_op == OP_CERASE: begin
                                if (wel) begin
                                    state  <= ST_ERASE;
                                    cnt    <= CW'(ERASE_MAX);
                                    addr_q <= '0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            cmd_op == OP_RSVD: err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_PROG: begin
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        state <= ST_IDLE;
                        wel   <= 1'b0;
                    end
                end
                ST_ERASE: begin
                    cnt    <= cnt - 1'b1;
                    addr_q <= addr_q + 1'b1;
                    if (last) begin
                        state <= ST_IDLE;
                        wel   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ospi_flash_core.sv
// Directed-vector bench for ospi_flash_core at default parameters.
module tb_ospi_flash_core;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       wel;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    ospi_flash_core dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy),
        .wel      (wel),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("issue_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        issue(3'd3, a, 8'h00);
        tick();
        chk("rd_valid", rd_valid, 1);
        d = rd_data;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    // Ticks until busy drops; returns the number of ticks taken.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("busy_timeout", 0, 1);
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        int n;
        issue(3'd1, 8'h00, 8'h00);
        issue(3'd4, a, d);
        wait_idle(n);
    endtask

    initial begin
        logic [7:0] d;
        int n;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_addr  = 8'h00;
        cmd_data  = 8'h00;
        #12;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wel", wel, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err", err, 0);
        tick();
        reset = 1'b0;
        tick();

        issue(3'd3, 8'h10, 8'h00);
        chk("rd_lat_early", rd_valid, 0);
        tick();
        chk("rd0_valid", rd_valid, 1);
        chk("rd0_data", rd_data, 8'hFF);
        chk("rd0_busy", busy, 0);
        chk("rd0_wel", wel, 0);
        tick();
        chk("rd_pulse_end", rd_valid, 0);
        chk("rd_data_hold", rd_data, 8'hFF);

        issue(3'd4, 8'h10, 8'hA5);
        chk("noel_err", err, 1);
        chk("noel_busy", busy, 0);
        tick();
        chk("noel_err_end", err, 0);
        rd_chk("noel_rd", 8'h10, 8'hFF);

        issue(3'd1, 8'h00, 8'h00);
        chk("wren_wel", wel, 1);
        issue(3'd4, 8'h10, 8'hA5);
        chk("prog_busy", busy, 1);
        chk("prog_ready", cmd_ready, 0);
        wait_idle(n);
        chk("prog_cycles", n, 4);
        chk("prog_wel", wel, 0);
        chk("prog_ready_end", cmd_ready, 1);
        rd_chk("prog_rd", 8'h10, 8'hA5);

        prog(8'h10, 8'h0F);
        rd_chk("prog_and", 8'h10, 8'h05);

        prog(8'h20, 8'h00);
        issue(3'd1, 8'h00, 8'h00);
        issue(3'd5, 8'h13, 8'h00);
        chk("se_busy", busy, 1);
        wait_idle(n);
        chk("se_cycles", n, 16);
        chk("se_wel", wel, 0);
        for (int i = 0; i < 16; i++) rd_chk("se_rd", 8'h10 + 8'(i), 8'hFF);
        rd_chk("se_keep", 8'h20, 8'h00);

        for (int i = 1; i < 16; i++) prog(8'h20 + 8'(i), 8'h00);
        issue(3'd1, 8'h00, 8'h00);
        issue(3'd5, 8'h20, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wel", wel, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 16; i++)
            rd_chk("rst_mid_rd", 8'h20 + 8'(i), (i < 5) ? 8'hFF : 8'h00);

        issue(3'd1, 8'h00, 8'h00);
        issue(3'd4, 8'h10, 8'h3C);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_addr  = 8'h10;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("hold_wait", n, 4);
        chk("hold_rdv_early", rd_valid, 0);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        chk("hold_rdv_acc", rd_valid, 0);
        tick();
        chk("hold_rdv", rd_valid, 1);
        chk("hold_data", rd_data, 8'h3C);

        // Back-to-back reads, one per cycle.
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_addr  = 8'h20;
        tick();
        cmd_addr  = 8'h30;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        chk("b2b_v0", rd_valid, 1);
        chk("b2b_d0", rd_data, 8'hFF);
        tick();
        chk("b2b_v1", rd_valid, 1);
        chk("b2b_d1", rd_data, 8'hFF);

        issue(3'd1, 8'h00, 8'h00);
        issue(3'd7, 8'h00, 8'h00);
        chk("rsvd_err", err, 1);
        chk("rsvd_wel", wel, 1);
        chk("rsvd_busy", busy, 0);
        tick();
        chk("rsvd_err_end", err, 0);
        issue(3'd2, 8'h00, 8'h00);
        chk("wrdi_wel", wel, 0);
        issue(3'd6, 8'h00, 8'h00);
        chk("ce_noel_err", err, 1);
        chk("ce_noel_busy", busy, 0);

        issue(3'd1, 8'h00, 8'h00);
        issue(3'd6, 8'h55, 8'h00);
        wait_idle(n);
        chk("ce_cycles", n, 256);
        rd_chk("ce_rd25", 8'h25, 8'hFF);
        rd_chk("ce_rd10", 8'h10, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
